// File: rtl/run_sequencer_if.sv
// run_sequencer_if: host command request and result byte stream of run_sequencer
// Ports (signals):
//   cmd_valid, cmd_ready      run request handshake
//   cmd_seed [63:0]           RNG seed for the run
//   cmd_inh_mask [RULES-1:0]  rules to inhibit for the run
//   res_valid, res_ready      result byte handshake
//   res_data [7:0]            result byte
//   res_last                  final byte of a result
// Modports: master = host side, slave = sequencer side.
interface run_sequencer_if #(
    parameter int RULES = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [63:0]      cmd_seed;
    logic [RULES-1:0] cmd_inh_mask;
    logic             res_valid;
    logic             res_ready;
    logic [7:0]       res_data;
    logic             res_last;
    modport master (
        output cmd_valid, cmd_seed, cmd_inh_mask, res_ready,
        input  cmd_ready, res_valid, res_data, res_last
    );
    modport slave (
        input  cmd_valid, cmd_seed, cmd_inh_mask, res_ready,
        output cmd_ready, res_valid, res_data, res_last
    );
endinterface

// File: rtl/run_sequencer.sv
// run_sequencer: drives one network-simulation datapath through a run and serializes its result
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   bus (slave)              command request in, result byte stream out
//   abort_i                  terminate the run in progress
//   dp_rst_o                 datapath reset (combinational, also follows rst)
//   dp_start_o               datapath start pulse
//   dp_seed_o                datapath seed, latched at command accept
//   dp_ld_inhibitor_o        inhibitor load strobe
//   dp_sel_inhibitor_o       inhibitor index
//   dp_network_state_i       datapath network state
//   dp_steady_state_i        datapath steady-state flag
//   dp_iteration_number_i    datapath iteration count
module run_sequencer #(
    parameter int RULES     = 16,
    parameter int LOG_RULES = 4,
    parameter int LOG_ITER  = 16,
    parameter int TIMEOUT   = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    run_sequencer_if.slave       bus,
    input  logic                 abort_i,
    output logic                 dp_rst_o,
    output logic                 dp_start_o,
    output logic [63:0]          dp_seed_o,
    output logic                 dp_ld_inhibitor_o,
    output logic [LOG_RULES-1:0] dp_sel_inhibitor_o,
    input  logic [RULES-1:0]     dp_network_state_i,
    input  logic                 dp_steady_state_i,
    input  logic [LOG_ITER-1:0]  dp_iteration_number_i
);
    localparam int ITB = (LOG_ITER + 7) / 8;
    localparam int STB = (RULES + 7) / 8;
    localparam int NB  = 1 + ITB + STB;
    localparam int PW  = 8 * (ITB + STB);
    localparam int BW  = $clog2(NB);
    typedef enum logic [2:0] {IDLE, CLR, INH, START, RUN, CAPTURE, SEND} state_t;
    state_t               state_q;
    logic [RULES-1:0]     mask_q;
    logic [RULES-1:0]     mask_d;
    logic [LOG_RULES-1:0] low_d;
    logic [31:0]          cnt_q;
    logic [4:0]           seq_q;
    logic [2:0]           flags_q;
    logic [PW-1:0]        pay_q;
    logic [PW-1:0]        pay_d;
    logic [BW-1:0]        idx_q;
    logic                 start_q;
    logic                 ld_q;
    logic [LOG_RULES-1:0] sel_q;
    logic [63:0]          seed_q;
    logic                 valid_q;
    logic [7:0]           data_q;
    logic                 last_q;
    // Lowest set bit of the pending mask is the next inhibitor to load.
    always_comb begin
        low_d = '0;
        for (int j = RULES - 1; j >= 0; j--)
            if (mask_q[j]) low_d = LOG_RULES'(j);
        mask_d = mask_q & ~(RULES'(1) << low_d);
    end
    // Bytes after the status byte: iteration then state, each LSB first, zero padded.
    assign pay_d = (PW'(dp_network_state_i) << (8 * ITB)) | PW'(dp_iteration_number_i);
    assign dp_rst_o           = rst | (state_q == CLR);
    assign bus.cmd_ready      = (state_q == IDLE) & ~rst;
    assign dp_start_o         = start_q;
    assign dp_seed_o          = seed_q;
    assign dp_ld_inhibitor_o  = ld_q;
    assign dp_sel_inhibitor_o = sel_q;
    assign bus.res_valid      = valid_q;
    assign bus.res_data       = data_q;
    assign bus.res_last       = last_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mask_q  <= '0;
            cnt_q   <= '0;
            seq_q   <= '0;
            flags_q <= '0;
            pay_q   <= '0;
            idx_q   <= '0;
            start_q <= 1'b0;
            ld_q    <= 1'b0;
            sel_q   <= '0;
            seed_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.cmd_valid) begin
                    seed_q  <= bus.cmd_seed;
                    mask_q  <= bus.cmd_inh_mask;
                    state_q <= CLR;
                end
                // CLR and INH share the load logic so a zero mask at CLR exit skips INH.
                CLR, INH: begin
                    if (abort_i) begin
                        ld_q    <= 1'b0;
                        mask_q  <= '0;
                        flags_q <= 3'b100;
                        state_q <= CAPTURE;
                    end else if (mask_q != '0) begin
                        ld_q    <= 1'b1;
                        sel_q   <= low_d;
                        mask_q  <= mask_d;
                        state_q <= INH;
                    end else begin
                        ld_q    <= 1'b0;
                        start_q <= 1'b1;
                        state_q <= START;
                    end
                end
                START: begin
                    start_q <= 1'b0;
                    cnt_q   <= '0;
                    flags_q <= 3'b100;
                    state_q <= abort_i ? CAPTURE : RUN;
                end
                // Exit priority: steady > abort > timeout.
                RUN: begin
                    cnt_q <= cnt_q + 32'd1;
                    if (dp_steady_state_i | abort_i | (cnt_q == 32'(TIMEOUT - 1))) begin
                        flags_q <= dp_steady_state_i ? 3'b001 : abort_i ? 3'b100 : 3'b010;
                        state_q <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    pay_q   <= pay_d;
                    data_q  <= {seq_q, flags_q};
                    valid_q <= 1'b1;
                    last_q  <= 1'b0;
                    idx_q   <= '0;
                    state_q <= SEND;
                end
                SEND: if (bus.res_ready) begin
                    if (idx_q == BW'(NB - 1)) begin
                        valid_q <= 1'b0;
                        data_q  <= '0;
                        last_q  <= 1'b0;
                        seq_q   <= seq_q + 5'd1;
                        state_q <= IDLE;
                    end else begin
                        data_q <= pay_q[7:0];
                        pay_q  <= pay_q >> 8;
                        idx_q  <= idx_q + 1'b1;
                        last_q <= idx_q == BW'(NB - 2);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: scoreboard bench for run_sequencer with directed runs
module tb_run_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        abort;
    logic        dp_rst, dp_start, dp_ld, dp_steady;
    logic [63:0] dp_seed;
    logic [3:0]  dp_sel;
    logic [15:0] dp_state, dp_iter;
    int          checks = 0, errs = 0;
    logic [8:0]  exp_q[$];
    int          ld_sel[$];
    int          ld_t[$];
    int          n_rst, n_start, t_rst, t_start, t_valid, cyc = 0;
    logic        held = 1'b0, pv = 1'b0;
    logic [9:0]  hold_v;
    always #5 clk = ~clk;
    run_sequencer_if #(.RULES(16)) bus();
    run_sequencer #(.RULES(16), .LOG_RULES(4), .LOG_ITER(16), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .bus(bus), .abort_i(abort),
        .dp_rst_o(dp_rst), .dp_start_o(dp_start), .dp_seed_o(dp_seed),
        .dp_ld_inhibitor_o(dp_ld), .dp_sel_inhibitor_o(dp_sel),
        .dp_network_state_i(dp_state), .dp_steady_state_i(dp_steady),
        .dp_iteration_number_i(dp_iter)
    );
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask
    // Monitor: logs datapath control activity and checks result bytes against the queue.
    always @(negedge clk) begin
        #2;
        cyc++;
        if (rst) begin
            held = 1'b0;
            pv   = 1'b0;
        end else begin
            if (dp_rst) begin n_rst++; t_rst = cyc; end
            if (dp_ld) begin ld_sel.push_back(int'(dp_sel)); ld_t.push_back(cyc); end
            if (dp_start) begin n_start++; t_start = cyc; end
            if (bus.res_valid && !pv) t_valid = cyc;
            pv = bus.res_valid;
            if (held) check("hold", {bus.res_valid, bus.res_last, bus.res_data}, hold_v);
            held = 1'b0;
            if (bus.res_valid && bus.res_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL extra_byte: got %0h expected none", {bus.res_last, bus.res_data});
                end else check("byte", {bus.res_last, bus.res_data}, exp_q.pop_front());
            end else if (bus.res_valid) begin
                held   = 1'b1;
                hold_v = {bus.res_valid, bus.res_last, bus.res_data};
            end
        end
    end
    task automatic tick();
        @(negedge clk);
    endtask
    task automatic clear_log();
        n_rst = 0; n_start = 0; t_rst = 0; t_start = 0; t_valid = 0;
        ld_sel.delete();
        ld_t.delete();
    endtask
    task automatic push5(input logic [7:0] st, input logic [15:0] it, input logic [15:0] ns);
        exp_q.push_back({1'b0, st});
        exp_q.push_back({1'b0, it[7:0]});
        exp_q.push_back({1'b0, it[15:8]});
        exp_q.push_back({1'b0, ns[7:0]});
        exp_q.push_back({1'b1, ns[15:8]});
    endtask
    task automatic issue(input logic [63:0] seed, input logic [15:0] mask);
        for (int i = 0; i < 100 && !bus.cmd_ready; i++) tick();
        check("cmd_ready", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_seed = seed;
        bus.cmd_inh_mask = mask;
        tick();
        bus.cmd_valid = 1'b0;
        check("clr_dp_rst", dp_rst, 1);
        check("clr_seed", dp_seed, seed);
    endtask
    task automatic wait_start();
        for (int i = 0; i < 100 && !dp_start; i++) tick();
        check("start_seen", dp_start, 1);
    endtask
    task automatic wait_done(input bit toggle);
        for (int i = 0; i < 200 && (exp_q.size() != 0 || bus.res_valid); i++) begin
            tick();
            if (toggle) bus.res_ready = ~bus.res_ready;
        end
        check("drained", exp_q.size(), 0);
        check("valid_low", bus.res_valid, 0);
        bus.res_ready = 1'b1;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        abort = 0; dp_steady = 0; dp_state = 0; dp_iter = 0;
        bus.cmd_valid = 0; bus.cmd_seed = 0; bus.cmd_inh_mask = 0; bus.res_ready = 1;
        #12;
        check("rst_dp_rst", dp_rst, 1);
        check("rst_cmd_ready", bus.cmd_ready, 0);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_dp_start", dp_start, 0);
        check("rst_dp_seed", dp_seed, 0);
        tick();
        rst = 0;
        tick();
        // Run 1: zero mask, steady on 5th RUN cycle, sequence 0.
        clear_log();
        dp_iter = 16'h0102; dp_state = 16'hA55A;
        push5(8'h01, dp_iter, dp_state);
        issue(64'h1, 16'h0);
        wait_start();
        repeat (5) tick();
        dp_steady = 1;
        tick();
        dp_steady = 0;
        wait_done(0);
        check("r1_ready_after", bus.cmd_ready, 1);
        check("r1_n_rst", n_rst, 1);
        check("r1_n_ld", ld_sel.size(), 0);
        check("r1_n_start", n_start, 1);
        check("r1_start_to_valid", t_valid - t_start, 7);
        // Run 2: mask 8005, timeout, sequence 1, res_ready toggling.
        clear_log();
        dp_iter = 16'h1234; dp_state = 16'hBEEF;
        push5(8'h0A, dp_iter, dp_state);
        issue(64'h0123456789ABCDEF, 16'h8005);
        wait_start();
        wait_done(1);
        check("r2_n_ld", ld_sel.size(), 3);
        if (ld_sel.size() == 3) begin
            check("r2_sel0", ld_sel[0], 0);
            check("r2_sel1", ld_sel[1], 2);
            check("r2_sel2", ld_sel[2], 15);
            check("r2_ld_after_clr", ld_t[0], t_rst + 1);
            check("r2_ld_consec", ld_t[2], ld_t[0] + 2);
            check("r2_start_after_ld", t_start, ld_t[2] + 1);
        end
        check("r2_n_start", n_start, 1);
        check("r2_run_cycles", t_valid - t_start - 2, 8);
        // Run 3: abort and steady in the same RUN cycle, sequence 2.
        clear_log();
        dp_iter = 16'h0007; dp_state = 16'h0003;
        push5(8'h11, dp_iter, dp_state);
        issue(64'h2, 16'h0);
        wait_start();
        repeat (3) tick();
        dp_steady = 1; abort = 1;
        tick();
        dp_steady = 0; abort = 0;
        wait_done(0);
        // Run 4: abort on the 2nd inhibitor load, sequence 3.
        clear_log();
        dp_iter = 16'h00FF; dp_state = 16'h8000;
        push5(8'h1C, dp_iter, dp_state);
        issue(64'h3, 16'h00F0);
        tick();
        tick();
        abort = 1;
        tick();
        abort = 0;
        wait_done(0);
        check("r4_n_ld", ld_sel.size(), 2);
        if (ld_sel.size() == 2) begin
            check("r4_sel0", ld_sel[0], 4);
            check("r4_sel1", ld_sel[1], 5);
        end
        check("r4_n_start", n_start, 0);
        // Run 5: rst after 2 bytes of a result, sequence 4.
        clear_log();
        dp_iter = 16'h5566; dp_state = 16'h7788;
        exp_q.push_back(9'h021);
        exp_q.push_back(9'h066);
        issue(64'hDEAD, 16'h0);
        wait_start();
        tick();
        dp_steady = 1;
        tick();
        dp_steady = 0;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
        check("r5_two_bytes", exp_q.size(), 0);
        bus.res_ready = 0;
        #3;
        rst = 1;
        #1;
        check("r5_rst_valid", bus.res_valid, 0);
        check("r5_rst_data", bus.res_data, 0);
        check("r5_rst_last", bus.res_last, 0);
        check("r5_rst_dp_rst", dp_rst, 1);
        check("r5_rst_cmd_ready", bus.cmd_ready, 0);
        check("r5_rst_seed", dp_seed, 0);
        tick();
        tick();
        rst = 0;
        bus.res_ready = 1;
        tick();
        // Run 6: timeout after reset, sequence back to 0.
        clear_log();
        dp_iter = 16'h0001; dp_state = 16'h0001;
        push5(8'h02, dp_iter, dp_state);
        issue(64'h5, 16'h0);
        wait_start();
        wait_done(0);
        check("r6_n_start", n_start, 1);
        check("r6_run_cycles", t_valid - t_start - 2, 8);
        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
